// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    ISSUE,
    WAIT,
    HOLD,
    DRAIN
  } fetch_state_t;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] WORD_MASK        = 32'hFFFF_FFFC;

endpackage

// File: rtl/instr_fetch.sv
// RV32I fetch stage: owns the PC, issues single outstanding imem reads and hands words to decode.
// Optional FETCH_MISALIGN_CHK_EN reports misaligned redirect targets instead of truncating them.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic        fetch_misalign
`endif
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  target;
  logic         target_bad;
  logic         pc_bad;

`ifdef FETCH_MISALIGN_CHK_EN
  assign target     = redirect_pc;
  assign target_bad = |redirect_pc[1:0];
  assign pc_bad     = |pc[1:0];
`else
  assign target     = redirect_pc & WORD_MASK;
  assign target_bad = 1'b0;
  assign pc_bad     = 1'b0;
`endif

  // A misaligned PC is never sent to memory; ISSUE re-reports it until redirected.
  assign imem_req  = !rst && (state == ISSUE) && !redirect_valid && !pc_bad;
  assign imem_addr = pc;

  // NOTE: all state below uses non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ISSUE;
      pc         <= RESET_PC;
      inst       <= NOP_INST;
      inst_pc    <= RESET_PC;
      inst_valid <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
      fetch_misalign <= 1'b0;
`endif
    end else begin
      case (state)
        ISSUE: begin
          if (redirect_valid) begin
            pc <= target;
            if (target_bad) begin
              inst       <= NOP_INST;
              inst_pc    <= target;
              inst_valid <= 1'b1;
              state      <= HOLD;
`ifdef FETCH_MISALIGN_CHK_EN
              fetch_misalign <= 1'b1;
`endif
            end
          end else if (pc_bad) begin
            inst       <= NOP_INST;
            inst_pc    <= pc;
            inst_valid <= 1'b1;
            state      <= HOLD;
`ifdef FETCH_MISALIGN_CHK_EN
            fetch_misalign <= 1'b1;
`endif
          end else begin
            state <= WAIT;
          end
        end

        WAIT: begin
          if (redirect_valid) begin
            pc <= target;
            if (!imem_rvalid) begin
              state <= DRAIN;
            end else if (target_bad) begin
              inst       <= NOP_INST;
              inst_pc    <= target;
              inst_valid <= 1'b1;
              state      <= HOLD;
`ifdef FETCH_MISALIGN_CHK_EN
              fetch_misalign <= 1'b1;
`endif
            end else begin
              state <= ISSUE;
            end
          end else if (imem_rvalid) begin
            inst       <= imem_rdata;
            inst_pc    <= pc;
            pc         <= pc + 32'd4;
            inst_valid <= 1'b1;
            state      <= HOLD;
          end
        end

        HOLD: begin
          if (redirect_valid) begin
            pc <= target;
            if (target_bad) begin
              inst       <= NOP_INST;
              inst_pc    <= target;
              inst_valid <= 1'b1;
              state      <= HOLD;
`ifdef FETCH_MISALIGN_CHK_EN
              fetch_misalign <= 1'b1;
`endif
            end else begin
              inst_valid <= 1'b0;
              state      <= ISSUE;
`ifdef FETCH_MISALIGN_CHK_EN
              fetch_misalign <= 1'b0;
`endif
            end
          end else if (inst_ready) begin
            inst_valid <= 1'b0;
            state      <= ISSUE;
`ifdef FETCH_MISALIGN_CHK_EN
            fetch_misalign <= 1'b0;
`endif
          end
        end

        DRAIN: begin
          // The stale response is dropped; a misaligned target is reported from ISSUE.
          if (redirect_valid) pc <= target;
          if (imem_rvalid) state <= ISSUE;
        end

        default: state <= ISSUE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch, including a second instance exercising PC wrap.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req, imem_rvalid, inst_valid, inst_ready, redirect_valid;
  logic [31:0] imem_addr, imem_rdata, inst, inst_pc, redirect_pc;
  logic        imem_req2, imem_rvalid2, inst_valid2, inst_ready2;
  logic [31:0] imem_addr2, imem_rdata2, inst2, inst_pc2;
`ifdef FETCH_MISALIGN_CHK_EN
  logic        fetch_misalign, fetch_misalign2;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef FETCH_MISALIGN_CHK_EN
    , .fetch_misalign(fetch_misalign)
`endif
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_rvalid(imem_rvalid2), .imem_rdata(imem_rdata2),
    .inst(inst2), .inst_pc(inst_pc2), .inst_valid(inst_valid2), .inst_ready(inst_ready2),
    .redirect_valid(1'b0), .redirect_pc(32'h0)
`ifdef FETCH_MISALIGN_CHK_EN
    , .fetch_misalign(fetch_misalign2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs driven and outputs checked 2 time units after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_rvalid2 = 1'b0; imem_rdata2 = 32'h0; inst_ready2 = 1'b1;

    // Reset state
    cyc();
    check("rst_req", imem_req, 0);
    check("rst_valid", inst_valid, 0);
    check("rst_inst", inst, 32'h0000_0013);
    check("rst_inst_pc", inst_pc, 32'h0);
`ifdef FETCH_MISALIGN_CHK_EN
    check("rst_misalign", fetch_misalign, 0);
`endif

    // First fetch, 1-cycle memory
    rst = 1'b0;
    #1;
    check("first_req", imem_req, 1);
    check("first_addr", imem_addr, 32'h0);
    cyc();
    check("wait_no_req", imem_req, 0);
    check("wait_not_valid", inst_valid, 0);
    imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0093;
    cyc();
    imem_rvalid = 1'b0; imem_rdata = 32'h0;
    check("first_valid", inst_valid, 1);
    check("first_inst", inst, 32'h00A0_0093);
    check("first_inst_pc", inst_pc, 32'h0);

    // Backpressure: five cycles in HOLD with ready low
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", inst_valid, 1);
      check("hold_inst", inst, 32'h00A0_0093);
      check("hold_inst_pc", inst_pc, 32'h0);
      check("hold_no_req", imem_req, 0);
      cyc();
    end
    inst_ready = 1'b1;
    cyc();
    inst_ready = 1'b0;
    #1;
    check("hs_valid_clr", inst_valid, 0);
    check("second_req", imem_req, 1);
    check("second_addr", imem_addr, 32'h4);

    // Redirect in WAIT, stale response three cycles later
    cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    cyc();
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    check("drain_no_req1", imem_req, 0);
    cyc();
    check("drain_no_req2", imem_req, 0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    cyc();
    imem_rvalid = 1'b0;
    #1;
    check("drain_discard_valid", inst_valid, 0);
    check("drain_inst_kept", inst, 32'h00A0_0093);
    check("redir_req", imem_req, 1);
    check("redir_addr", imem_addr, 32'h0000_0100);

    cyc();
    imem_rvalid = 1'b1; imem_rdata = 32'h0010_0113;
    cyc();
    imem_rvalid = 1'b0;
    check("redir_inst", inst, 32'h0010_0113);
    check("redir_inst_pc", inst_pc, 32'h0000_0100);

    // Redirect in HOLD together with inst_ready
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0040; inst_ready = 1'b1;
    cyc();
    redirect_valid = 1'b0; inst_ready = 1'b0;
    #1;
    check("hold_redir_valid", inst_valid, 0);
    check("hold_redir_req", imem_req, 1);
    check("hold_redir_addr", imem_addr, 32'h0000_0040);

    // Redirect in ISSUE suppresses the request
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    #1;
    check("issue_redir_no_req", imem_req, 0);
    cyc();
    redirect_valid = 1'b0;
    #1;
    check("issue_redir_addr", imem_addr, 32'h0000_0200);
    check("issue_redir_req", imem_req, 1);

    // Redirect and response in the same WAIT cycle
    cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0300; imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
    cyc();
    redirect_valid = 1'b0; imem_rvalid = 1'b0;
    #1;
    check("wait_both_valid", inst_valid, 0);
    check("wait_both_addr", imem_addr, 32'h0000_0300);
    check("wait_both_req", imem_req, 1);

    // Misaligned redirect
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
    #1;
    check("mis_no_req", imem_req, 0);
    cyc();
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    #1;
`ifdef FETCH_MISALIGN_CHK_EN
    check("mis_flag", fetch_misalign, 1);
    check("mis_valid", inst_valid, 1);
    check("mis_inst", inst, 32'h0000_0013);
    check("mis_inst_pc", inst_pc, 32'h0000_0102);
    check("mis_hold_no_req", imem_req, 0);
    inst_ready = 1'b1;
    cyc();
    inst_ready = 1'b0;
    check("mis_flag_clr", fetch_misalign, 0);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    cyc();
    redirect_valid = 1'b0;
    #1;
`endif
    check("mis_fix_req", imem_req, 1);
    check("mis_fix_addr", imem_addr, 32'h0000_0100);

    // Redirect and stale response together in DRAIN keep the newer target
    cyc();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0500;
    cyc();
    redirect_pc = 32'h0000_0600; imem_rvalid = 1'b1;
    #1;
    check("drain_both_no_req", imem_req, 0);
    cyc();
    redirect_valid = 1'b0; imem_rvalid = 1'b0;
    #1;
    check("drain_both_valid", inst_valid, 0);
    check("drain_both_req", imem_req, 1);
    check("drain_both_addr", imem_addr, 32'h0000_0600);

    // PC wrap on the second instance, idle in WAIT since reset release
    check("wrap_first_addr", imem_addr2, 32'hFFFF_FFFC);
    check("wrap_wait_no_req", imem_req2, 0);
    imem_rvalid2 = 1'b1; imem_rdata2 = 32'h0000_0013;
    cyc();
    imem_rvalid2 = 1'b0;
    check("wrap_inst_pc", inst_pc2, 32'hFFFF_FFFC);
    check("wrap_valid", inst_valid2, 1);
    cyc();
    check("wrap_req", imem_req2, 1);
    check("wrap_addr", imem_addr2, 32'h0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
